// File: rtl/key_hole_queue.sv
// key_hole_queue: maps PS/2 set-2 game keys to mole hole indices 0-8, applies a
// same-hole repeat lockout, queues accepted hits in a small FIFO (valid/ready),
// and turns Space/P into single-cycle start/pause pulses that bypass the queue.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   key_in            - scancode, qualified by key_valid_in (one-cycle pulse)
//   hole_ready        - consumer pops the head when hole_valid is also high
//   hole_valid        - FIFO non-empty
//   hole_idx          - head entry hole index
//   start_pulse       - one-cycle pulse on Space (also flushes queue/lockout)
//   pause_pulse       - one-cycle pulse on P
//   fifo_count        - current occupancy
//   overflow          - sticky: a hit was dropped because the FIFO was full
module key_hole_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned LOCKOUT_CYCLES = 5000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               key_in,
  input  logic                     key_valid_in,
  input  logic                     hole_ready,
  output logic                     hole_valid,
  output logic [3:0]               hole_idx,
  output logic                     start_pulse,
  output logic                     pause_pulse,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [LW-1:0] LOCK_RELOAD = (LOCKOUT_CYCLES == 0) ? '0 : LW'(LOCKOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);
  localparam logic [3:0]    IDX_NONE    = 4'hF;

  localparam logic [1:0] CLS_NONE  = 2'd0;
  localparam logic [1:0] CLS_HOLE  = 2'd1;
  localparam logic [1:0] CLS_START = 2'd2;
  localparam logic [1:0] CLS_PAUSE = 2'd3;

  logic [1:0]    w_dec_cls;
  logic [3:0]    w_dec_idx;
  logic [1:0]    r_cls;
  logic [3:0]    r_idx;

  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [3:0]    r_head;
  logic          r_ovf;
  logic          r_start;
  logic          r_pause;
  logic [LW-1:0] r_lock;
  logic [3:0]    r_last;

  logic          w_is_start;
  logic          w_locked;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop_full;
  logic [PW-1:0] w_rd_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [3:0]    w_head_nxt;

  // Scancode decode into class + hole index
  always_comb begin
    w_dec_cls = CLS_NONE;
    w_dec_idx = 4'd0;
    case (key_in)
      8'h15: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd0; end
      8'h1D: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd1; end
      8'h24: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd2; end
      8'h1C: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd3; end
      8'h1B: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd4; end
      8'h23: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd5; end
      8'h1A: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd6; end
      8'h22: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd7; end
      8'h21: begin w_dec_cls = CLS_HOLE; w_dec_idx = 4'd8; end
      8'h29: w_dec_cls = CLS_START;
      8'h4D: w_dec_cls = CLS_PAUSE;
      default: ;
    endcase
  end

  // Stage 1: decode register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cls <= CLS_NONE;
      r_idx <= 4'd0;
    end else begin
      r_cls <= key_valid_in ? w_dec_cls : CLS_NONE;
      r_idx <= w_dec_idx;
    end
  end

  // Stage 2 decisions; start discards any pop in its cycle
  always_comb begin
    w_is_start  = (r_cls == CLS_START);
    w_locked    = (r_last == r_idx) && (r_lock != '0);
    w_full      = (r_count == FULL_COUNT);
    w_pop       = r_valid && hole_ready && !w_is_start;
    w_push      = (r_cls == CLS_HOLE) && !w_locked && (!w_full || w_pop);
    w_drop_full = (r_cls == CLS_HOLE) && !w_locked && w_full && !w_pop;
    w_rd_nxt    = w_pop ? (r_rd + PW'(1)) : r_rd;
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
    // Next head: the entry being written if it lands at the new read slot
    if (w_count_nxt == '0)                w_head_nxt = r_head;
    else if (w_push && (r_wr == w_rd_nxt)) w_head_nxt = r_idx;
    else                                   w_head_nxt = r_mem[w_rd_nxt];
  end

  // FIFO storage, no reset needed since pointers are reset
  always_ff @(posedge clk) begin
    if (!reset && !w_is_start && w_push) r_mem[r_wr] <= r_idx;
  end

  // Control state, lockout and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= 4'd0;
      r_ovf   <= 1'b0;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_lock  <= '0;
      r_last  <= IDX_NONE;
    end else begin
      r_start <= w_is_start;
      r_pause <= (r_cls == CLS_PAUSE);
      if (w_is_start) begin
        r_rd    <= '0;
        r_wr    <= '0;
        r_count <= '0;
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
        r_lock  <= '0;
        r_last  <= IDX_NONE;
      end else begin
        if (w_push) begin
          r_wr   <= r_wr + PW'(1);
          r_last <= r_idx;
          r_lock <= LOCK_RELOAD;
        end else if (r_lock != '0) begin
          r_lock <= r_lock - LW'(1);
        end
        if (w_drop_full) r_ovf <= 1'b1;
        r_rd    <= w_rd_nxt;
        r_count <= w_count_nxt;
        r_valid <= (w_count_nxt != '0);
        r_head  <= w_head_nxt;
      end
    end
  end

  assign hole_valid  = r_valid;
  assign hole_idx    = r_head;
  assign start_pulse = r_start;
  assign pause_pulse = r_pause;
  assign fifo_count  = r_count;
  assign overflow    = r_ovf;

endmodule

// File: doc/key_hole_queue.md
Name: key_hole_queue

Overview:
- Sits directly downstream of the PS/2 key-press stage.
- Consumes one-cycle key-press pulses with set-2 scancodes and maps the nine game keys to mole hole indices 0–8.
- Suppresses rapid same-hole repeats and buffers accepted hits in a small FIFO for the game FSM, using a valid/ready handshake.
- Decodes game command keys into single-cycle pulses that bypass the queue.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
LOCKOUT_CYCLES, 5000000, same-hole repeat lockout window in clk cycles (50 ms at 100 MHz); 0 disables lockout.

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
key_in  input  8  scancode, qualified by key_valid_in
key_valid_in  input  1  one-cycle pulse per new key press
hole_ready  input  1  consumer accepts head entry when high with hole_valid
hole_valid  output  1  FIFO non-empty
hole_idx  output  4  head entry hole index, 0–8
start_pulse  output  1  one-cycle pulse on Space (0x29)
pause_pulse  output  1  one-cycle pulse on P (0x4D)
fifo_count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky flag: a hit was dropped because the FIFO was full

Behaviour:
- Reset, sampled at a clk edge with reset high:
  - hole_valid=0, hole_idx=0, start_pulse=0, pause_pulse=0, fifo_count=0, overflow=0.
  - Lockout counter cleared to 0; last accepted index set to 0xF (none); decode register cleared.
  - Reset overrides all other activity in the same cycle, including mid-lockout and mid-handshake.
- Key map (set 2):
  - Q 0x15→0, W 0x1D→1, E 0x24→2
  - A 0x1C→3, S 0x1B→4, D 0x23→5
  - Z 0x1A→6, X 0x22→7, C 0x21→8
  - Every other scancode except 0x29 and 0x4D is dropped silently and has no side effects.
- Stage 1, edge E0 where key_valid_in=1:
  - Registers the decoded class (hole, start, pause, none) and the index.
  - key_in is ignored when key_valid_in=0.
- Stage 2, edge E1 = E0+1:
  - Hole class: if index equals the last accepted index and the lockout counter is nonzero, the hit is dropped; counter and last index are unchanged.
  - Hole class, FIFO full with no pop at E1: the hit is dropped, overflow←1, and lockout state is unchanged.
  - Hole class, otherwise: the index is written at the tail, last index←index, counter←LOCKOUT_CYCLES−1.
    - With LOCKOUT_CYCLES=0 the counter stays 0, so lockout is effectively disabled.
  - Start class: start_pulse=1 for exactly the cycle after E1.
    - At E1 the FIFO is flushed (count←0), overflow←0, counter←0, last index←0xF.
    - A pop requested at E1 is discarded.
  - Pause class: pause_pulse=1 for the cycle after E1; no other side effects.
- Latency: a hit arriving at an empty FIFO gives hole_valid=1 and hole_idx=index in the cycle after E1, i.e. 2 edges after key sampling.
- Lockout counter:
  - Decrements by 1 each cycle while nonzero and saturates at 0.
  - Reloads only on an accepted write.
  - A different hole index is never locked out.
- FIFO:
  - Pop occurs at an edge where hole_valid&&hole_ready.
  - hole_idx always shows the head entry, with no read latency.
  - Pop when empty: no effect.
  - Simultaneous push and pop: both occur, and count is unchanged, including when full.
  - hole_idx holds its last value when empty (don't-care for checking).
  - Read and write pointers wrap modulo DEPTH.
- Back-to-back key_valid_in pulses on consecutive cycles are each processed; throughput is 1 key/cycle.
- overflow stays set until reset or start.

Test Plan:
- Reset, then pulse key_in=0x1D, hole_ready=0 → after 2 edges hole_valid=1, hole_idx=1, fifo_count=1; hole_ready=1 for one cycle → hole_valid=0, fifo_count=0.
- LOCKOUT_CYCLES=10: 0x15 at t=0, 0x15 at t=5, 0x15 at t=15, 0x1D at t=6 → entries queued in order 0,1,0 (the t=5 hit is dropped).
- DEPTH=4, hole_ready=0, LOCKOUT_CYCLES=0: keys Q,W,E,A,S → fifo_count=4, overflow=1, pop order 0,1,2,3.
- FIFO full, then a hit push concurrent with hole_ready=1 → fifo_count stays 4, overflow stays 0, new index appears last.
- Queue holds 2 entries with overflow=1; key 0x29 → start_pulse one cycle, fifo_count=0, overflow=0, hole_valid=0. Key 0x4D → pause_pulse one cycle, queue untouched. Key 0x76 → no output change.
- Reset asserted while the lockout counter is nonzero and the FIFO holds 3 entries → next cycle all outputs 0; an immediate repeat of the same hole key is accepted.
